// File: rtl/segre_mem_stage.sv
// Segre memory stage: EX/MEM register, data-memory load/store handshake, load alignment and
// extension, write-back payload and MEM bypass value. memop_type_i: 0 byte, 1 half, 2 word.
module segre_mem_stage #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned REG_SIZE  = 5
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 valid_ex_i,
    input  logic [WORD_SIZE-1:0] alu_res_i,
    input  logic                 rf_we_i,
    input  logic [REG_SIZE-1:0]  rf_waddr_i,
    input  logic [WORD_SIZE-1:0] rf_st_data_i,
    input  logic [1:0]           memop_type_i,
    input  logic                 memop_rd_i,
    input  logic                 memop_wr_i,
    input  logic                 memop_sign_ext_i,
    input  logic [ADDR_SIZE-1:0] seq_new_pc_i,
    input  logic                 is_jaljalr_i,
    input  logic                 block_mem_i,
    input  logic                 inject_nops_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [WORD_SIZE-1:0] mem_rdata_i,
    output logic                 stall_mem_o,
    output logic                 misaligned_o,
    output logic [WORD_SIZE-1:0] op_res_stage_mem_o,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_wdata_o,
    output logic                 valid_mem_o
);

    localparam logic [1:0] MemopByte = 2'd0;
    localparam logic [1:0] MemopHalf = 2'd1;
    localparam logic [1:0] MemopWord = 2'd2;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e r_state;
    state_e w_state_nxt;

    // EX/MEM register
    logic                 r_valid;
    logic [WORD_SIZE-1:0] r_alu_res;
    logic                 r_rf_we;
    logic [REG_SIZE-1:0]  r_waddr;
    logic [WORD_SIZE-1:0] r_st_data;
    logic [1:0]           r_type;
    logic                 r_rd;
    logic                 r_wr;
    logic                 r_sign_ext;
    logic [ADDR_SIZE-1:0] r_seq_pc;
    logic                 r_is_jal;
    logic [WORD_SIZE-1:0] r_rdata;

    logic                 w_memop;
    logic                 w_misaligned;
    logic                 w_issue;
    logic                 w_req;
    logic                 w_stall;
    logic                 w_ack;
    logic                 w_valid_mem;
    logic [3:0]           w_be;
    logic [WORD_SIZE-1:0] w_st_lanes;
    logic [WORD_SIZE-1:0] w_ld_word;
    logic [7:0]           w_ld_byte;
    logic [15:0]          w_ld_half;
    logic [WORD_SIZE-1:0] w_ld_data;
    logic [WORD_SIZE-1:0] w_non_ld;
    logic [WORD_SIZE-1:0] w_wb_data;

    assign w_memop      = r_valid & (r_rd | r_wr);
    assign w_misaligned = w_memop & (((r_type == MemopHalf) & r_alu_res[0]) |
                                     ((r_type == MemopWord) & (r_alu_res[1:0] != 2'b00)));
    assign w_issue      = w_memop & ~w_misaligned;

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_issue) begin
                    if (mem_ack_i) begin
                        w_state_nxt = block_mem_i ? StDone : StIdle;
                    end else begin
                        w_state_nxt = StWait;
                    end
                end
            end
            StWait: begin
                if (mem_ack_i) begin
                    w_state_nxt = block_mem_i ? StDone : StIdle;
                end
            end
            StDone: begin
                if (!block_mem_i) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM: outputs; DONE never re-issues, so one request per instruction
    always_comb begin
        w_req   = 1'b0;
        w_stall = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_req   = w_issue;
                w_stall = w_issue & ~mem_ack_i;
            end
            StWait: begin
                w_req   = 1'b1;
                w_stall = ~mem_ack_i;
            end
            StDone: begin
                w_req   = 1'b0;
                w_stall = 1'b0;
            end
            default: begin
                w_req   = 1'b0;
                w_stall = 1'b0;
            end
        endcase
    end

    assign w_ack = w_req & mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            r_valid    <= 1'b0;
            r_alu_res  <= '0;
            r_rf_we    <= 1'b0;
            r_waddr    <= '0;
            r_st_data  <= '0;
            r_type     <= MemopByte;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_sign_ext <= 1'b0;
            r_seq_pc   <= '0;
            r_is_jal   <= 1'b0;
        end else if (!(block_mem_i || w_stall)) begin
            if (inject_nops_i) begin
                r_valid <= 1'b0;
                r_rf_we <= 1'b0;
                r_rd    <= 1'b0;
                r_wr    <= 1'b0;
            end else begin
                r_valid    <= valid_ex_i;
                r_alu_res  <= alu_res_i;
                r_rf_we    <= rf_we_i;
                r_waddr    <= rf_waddr_i;
                r_st_data  <= rf_st_data_i;
                r_type     <= memop_type_i;
                r_rd       <= memop_rd_i;
                r_wr       <= memop_wr_i;
                r_sign_ext <= memop_sign_ext_i;
                r_seq_pc   <= seq_new_pc_i;
                r_is_jal   <= is_jaljalr_i;
            end
        end
    end

    // Read data is kept so a load finished while blocked can retire later from DONE
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            r_rdata <= '0;
        end else if (w_ack) begin
            r_rdata <= mem_rdata_i;
        end
    end

    always_comb begin
        w_be       = 4'hF;
        w_st_lanes = r_st_data;
        unique case (r_type)
            MemopByte: begin
                w_be       = 4'b0001 << r_alu_res[1:0];
                w_st_lanes = WORD_SIZE'({4{r_st_data[7:0]}});
            end
            MemopHalf: begin
                w_be       = 4'b0011 << r_alu_res[1:0];
                w_st_lanes = WORD_SIZE'({2{r_st_data[15:0]}});
            end
            default: begin
                w_be       = 4'hF;
                w_st_lanes = r_st_data;
            end
        endcase
    end

    assign w_ld_word = w_ack ? mem_rdata_i : r_rdata;
    assign w_ld_byte = w_ld_word[{r_alu_res[1:0], 3'b000} +: 8];
    assign w_ld_half = w_ld_word[{r_alu_res[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_data = w_ld_word;
        unique case (r_type)
            MemopByte: w_ld_data = {{(WORD_SIZE - 8){r_sign_ext & w_ld_byte[7]}}, w_ld_byte};
            MemopHalf: w_ld_data = {{(WORD_SIZE - 16){r_sign_ext & w_ld_half[15]}}, w_ld_half};
            default:   w_ld_data = w_ld_word;
        endcase
    end

    assign w_non_ld  = r_is_jal ? WORD_SIZE'(r_seq_pc) : r_alu_res;
    assign w_wb_data = r_rd ? w_ld_data : w_non_ld;

    assign w_valid_mem = r_valid & ~w_stall & ~block_mem_i;

    // rsn_i gating keeps every output at zero while reset is held
    assign mem_req_o          = rsn_i & w_req;
    assign mem_we_o           = mem_req_o & r_wr;
    assign mem_addr_o         = rsn_i ? {r_alu_res[ADDR_SIZE-1:2], 2'b00} : '0;
    assign mem_be_o           = mem_req_o ? w_be : 4'b0000;
    assign mem_wdata_o        = mem_we_o ? w_st_lanes : '0;
    assign stall_mem_o        = rsn_i & w_stall;
    assign misaligned_o       = rsn_i & w_misaligned;
    assign valid_mem_o        = rsn_i & w_valid_mem;
    assign rf_we_o            = r_rf_we & valid_mem_o & ~w_misaligned;
    assign rf_waddr_o         = rsn_i ? r_waddr : '0;
    assign rf_wdata_o         = rsn_i ? w_wb_data : '0;
    // Loads are never bypassed from MEM, so they expose the address instead
    assign op_res_stage_mem_o = !rsn_i ? '0 : (r_rd ? r_alu_res : w_non_ld);

endmodule

// File: tb/tb_segre_mem_stage.sv
// Scoreboard bench for segre_mem_stage: stimulus queues expected write-back, memory
// transactions and signal probes; a negedge monitor pops and compares them.
module tb_segre_mem_stage;

    localparam logic [1:0] TyB = 2'd0;
    localparam logic [1:0] TyH = 2'd1;
    localparam logic [1:0] TyW = 2'd2;

    localparam int PReq = 0, PStall = 1, PValid = 2, PRfWe = 3, PMis = 4, PAllOut = 5;
    localparam int PStallCnt = 6, PReqCnt = 7, PTimeouts = 8, PWbQ = 9, PMtQ = 10;
    localparam int PWdata = 11;

    logic        clk = 1'b0;
    logic        rsn_i = 1'b0;
    logic        valid_ex_i = 1'b0;
    logic [31:0] alu_res_i = '0;
    logic        rf_we_i = 1'b0;
    logic [4:0]  rf_waddr_i = '0;
    logic [31:0] rf_st_data_i = '0;
    logic [1:0]  memop_type_i = '0;
    logic        memop_rd_i = 1'b0;
    logic        memop_wr_i = 1'b0;
    logic        memop_sign_ext_i = 1'b0;
    logic [31:0] seq_new_pc_i = '0;
    logic        is_jaljalr_i = 1'b0;
    logic        block_mem_i = 1'b0;
    logic        inject_nops_i = 1'b0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_req_o, mem_we_o, stall_mem_o, misaligned_o, rf_we_o, valid_mem_o;
    logic [31:0] mem_addr_o, mem_wdata_o, op_res_stage_mem_o, rf_wdata_o;
    logic [3:0]  mem_be_o;
    logic [4:0]  rf_waddr_o;

    always #5 clk = ~clk;

    segre_mem_stage dut (
        .clk_i              (clk),
        .rsn_i              (rsn_i),
        .valid_ex_i         (valid_ex_i),
        .alu_res_i          (alu_res_i),
        .rf_we_i            (rf_we_i),
        .rf_waddr_i         (rf_waddr_i),
        .rf_st_data_i       (rf_st_data_i),
        .memop_type_i       (memop_type_i),
        .memop_rd_i         (memop_rd_i),
        .memop_wr_i         (memop_wr_i),
        .memop_sign_ext_i   (memop_sign_ext_i),
        .seq_new_pc_i       (seq_new_pc_i),
        .is_jaljalr_i       (is_jaljalr_i),
        .block_mem_i        (block_mem_i),
        .inject_nops_i      (inject_nops_i),
        .mem_req_o          (mem_req_o),
        .mem_we_o           (mem_we_o),
        .mem_addr_o         (mem_addr_o),
        .mem_be_o           (mem_be_o),
        .mem_wdata_o        (mem_wdata_o),
        .mem_ack_i          (mem_ack_i),
        .mem_rdata_i        (mem_rdata_i),
        .stall_mem_o        (stall_mem_o),
        .misaligned_o       (misaligned_o),
        .op_res_stage_mem_o (op_res_stage_mem_o),
        .rf_we_o            (rf_we_o),
        .rf_waddr_o         (rf_waddr_o),
        .rf_wdata_o         (rf_wdata_o),
        .valid_mem_o        (valid_mem_o)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] opres;
        logic        mis;
        logic        chk_data;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mt_t;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } probe_t;

    wb_t    wbq[$];
    mt_t    mtq[$];
    probe_t pq[$];

    int total = 0;
    int bad = 0;
    int stall_cnt = 0;
    int req_cnt = 0;
    int to_cnt = 0;
    int cfg_lat = 0;
    logic [31:0] cfg_rdata = '0;
    int mem_cnt = 0;

    function automatic string pname(input int k);
        case (k)
            PReq:      return "mem_req";
            PStall:    return "stall_mem";
            PValid:    return "valid_mem";
            PRfWe:     return "rf_we";
            PMis:      return "misaligned";
            PAllOut:   return "any_output_set";
            PStallCnt: return "stall_cycles";
            PReqCnt:   return "req_cycles";
            PTimeouts: return "timeouts";
            PWbQ:      return "wb_queue_left";
            PMtQ:      return "mem_queue_left";
            default:   return "rf_wdata";
        endcase
    endfunction

    function automatic logic [31:0] pact(input int k);
        case (k)
            PReq:      return {31'b0, mem_req_o};
            PStall:    return {31'b0, stall_mem_o};
            PValid:    return {31'b0, valid_mem_o};
            PRfWe:     return {31'b0, rf_we_o};
            PMis:      return {31'b0, misaligned_o};
            PAllOut:   return {31'b0, |{mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
                                       stall_mem_o, misaligned_o, op_res_stage_mem_o, rf_we_o,
                                       rf_waddr_o, rf_wdata_o, valid_mem_o}};
            PStallCnt: return stall_cnt;
            PReqCnt:   return req_cnt;
            PTimeouts: return to_cnt;
            PWbQ:      return wbq.size();
            PMtQ:      return mtq.size();
            default:   return rf_wdata_o;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: probes first, then retire/transaction scoreboards, then cycle counters
    always @(negedge clk) begin
        probe_t p;
        wb_t    w;
        mt_t    m;
        while (pq.size() > 0) begin
            p = pq.pop_front();
            cmp(pname(p.kind), pact(p.kind), p.exp);
        end
        if (valid_mem_o) begin
            if (wbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got retire of wdata %h expected none", rf_wdata_o);
            end else begin
                w = wbq.pop_front();
                cmp("wb_we", {31'b0, rf_we_o}, {31'b0, w.we});
                cmp("wb_misaligned", {31'b0, misaligned_o}, {31'b0, w.mis});
                cmp("wb_opres", op_res_stage_mem_o, w.opres);
                if (w.chk_data) begin
                    cmp("wb_waddr", {27'b0, rf_waddr_o}, {27'b0, w.waddr});
                    cmp("wb_wdata", rf_wdata_o, w.wdata);
                end
            end
        end
        if (mem_req_o && mem_ack_i) begin
            if (mtq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mem_unexpected: got access at %h expected none", mem_addr_o);
            end else begin
                m = mtq.pop_front();
                cmp("mem_addr", mem_addr_o, m.addr);
                cmp("mem_we", {31'b0, mem_we_o}, {31'b0, m.we});
                cmp("mem_be", {28'b0, mem_be_o}, {28'b0, m.be});
                cmp("mem_wdata", mem_wdata_o, m.wdata);
            end
        end
        if (stall_mem_o) stall_cnt++;
        if (mem_req_o) req_cnt++;
    end

    // Memory model: acks after cfg_lat request cycles with no ack
    always @(posedge clk) begin
        #1;
        if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            mem_cnt = 0;
        end else if (mem_req_o) begin
            if (mem_cnt >= cfg_lat) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = cfg_rdata;
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic probe(input int k, input logic [31:0] e);
        probe_t p;
        p.kind = k;
        p.exp = e;
        pq.push_back(p);
    endtask

    task automatic exp_wb(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [31:0] opr, input logic mis, input logic chk);
        wb_t w;
        w.we = we; w.waddr = wa; w.wdata = wd; w.opres = opr; w.mis = mis; w.chk_data = chk;
        wbq.push_back(w);
    endtask

    task automatic exp_mt(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd);
        mt_t m;
        m.addr = a; m.we = we; m.be = be; m.wdata = wd;
        mtq.push_back(m);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one EX instruction until the stage accepts it
    task automatic send(input logic [31:0] alu, input logic we, input logic [4:0] wa,
                        input logic [31:0] st, input logic [1:0] ty, input logic rd,
                        input logic wr, input logic sx, input logic [31:0] pc,
                        input logic jal);
        logic hold;
        bit   ok;
        valid_ex_i = 1'b1; alu_res_i = alu; rf_we_i = we; rf_waddr_i = wa;
        rf_st_data_i = st; memop_type_i = ty; memop_rd_i = rd; memop_wr_i = wr;
        memop_sign_ext_i = sx; seq_new_pc_i = pc; is_jaljalr_i = jal;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            hold = stall_mem_o | block_mem_i;
            tick();
            if (!hold) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            to_cnt++;
            probe(PTimeouts, 0);
        end
        valid_ex_i = 1'b0; rf_we_i = 1'b0; memop_rd_i = 1'b0; memop_wr_i = 1'b0;
        is_jaljalr_i = 1'b0;
    endtask

    task automatic wait_retire();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wbq.size() == 0 && mtq.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            to_cnt++;
            probe(PTimeouts, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        tick();
        tick();
        probe(PAllOut, 0);
        tick();
        rsn_i = 1'b1;
        probe(PAllOut, 0);
        probe(PValid, 0);
        tick();

        // ALU result and JAL link value
        exp_wb(1'b1, 5'd5, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1);
        send(32'h1234, 1'b1, 5'd5, '0, TyW, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        probe(PReq, 0);
        probe(PValid, 1);
        wait_retire();
        exp_wb(1'b1, 5'd1, 32'h0000_0044, 32'h0000_0044, 1'b0, 1'b1);
        send(32'h40, 1'b1, 5'd1, '0, TyW, 1'b0, 1'b0, 1'b0, 32'h44, 1'b1);
        wait_retire();

        // LB sign-extended, three wait cycles
        cfg_lat = 3;
        cfg_rdata = 32'h80FF_0000;
        exp_mt(32'h100, 1'b0, 4'b1000, 32'h0);
        exp_wb(1'b1, 5'd7, 32'hFFFF_FF80, 32'h0000_0103, 1'b0, 1'b1);
        snap = stall_cnt;
        send(32'h103, 1'b1, 5'd7, '0, TyB, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        probe(PStall, 1);
        wait_retire();
        probe(PStallCnt, snap + 3);

        // SH with same-cycle ack
        cfg_lat = 0;
        cfg_rdata = 32'h0;
        exp_mt(32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD);
        exp_wb(1'b0, 5'd0, 32'h0, 32'h0000_0202, 1'b0, 1'b0);
        send(32'h202, 1'b0, 5'd0, 32'hABCD, TyH, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        probe(PStall, 0);
        probe(PRfWe, 0);
        probe(PValid, 1);
        wait_retire();

        // Misaligned LW
        exp_wb(1'b0, 5'd9, 32'h0, 32'h0000_0301, 1'b1, 1'b0);
        send(32'h301, 1'b1, 5'd9, '0, TyW, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        probe(PMis, 1);
        probe(PReq, 0);
        probe(PRfWe, 0);
        probe(PValid, 1);
        wait_retire();

        // LHU acked while blocked: DONE, single request
        cfg_rdata = 32'h9876_0000;
        exp_mt(32'h0, 1'b0, 4'b1100, 32'h0);
        exp_wb(1'b1, 5'd10, 32'h0000_9876, 32'h0000_0002, 1'b0, 1'b1);
        snap = req_cnt;
        send(32'h002, 1'b1, 5'd10, '0, TyH, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        block_mem_i = 1'b1;
        probe(PValid, 0);
        tick();
        probe(PReq, 0);
        probe(PValid, 0);
        tick();
        block_mem_i = 1'b0;
        probe(PValid, 1);
        probe(PWdata, 32'h0000_9876);
        wait_retire();
        probe(PReqCnt, snap + 1);

        // SB one wait cycle, LH sign-extended two wait cycles
        cfg_lat = 1;
        exp_mt(32'h0, 1'b1, 4'b0010, 32'h5A5A_5A5A);
        exp_wb(1'b0, 5'd0, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h001, 1'b0, 5'd0, 32'h5A, TyB, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        wait_retire();
        cfg_lat = 2;
        cfg_rdata = 32'h1234_8001;
        exp_mt(32'h0, 1'b0, 4'b0011, 32'h0);
        exp_wb(1'b1, 5'd11, 32'hFFFF_8001, 32'h0, 1'b0, 1'b1);
        send(32'h000, 1'b1, 5'd11, '0, TyH, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        wait_retire();

        // Reset while waiting abandons the access
        cfg_lat = 100;
        send(32'h400, 1'b1, 5'd12, '0, TyW, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        probe(PStall, 1);
        tick();
        probe(PReq, 1);
        tick();
        rsn_i = 1'b0;
        probe(PAllOut, 0);
        tick();
        rsn_i = 1'b1;
        probe(PReq, 0);
        probe(PStall, 0);
        probe(PAllOut, 0);
        tick();

        // Bubble injection, then a normal instruction afterwards
        cfg_lat = 0;
        valid_ex_i = 1'b1; alu_res_i = 32'h55; rf_we_i = 1'b1; rf_waddr_i = 5'd3;
        inject_nops_i = 1'b1;
        tick();
        inject_nops_i = 1'b0;
        valid_ex_i = 1'b0;
        rf_we_i = 1'b0;
        probe(PValid, 0);
        probe(PRfWe, 0);
        tick();
        exp_wb(1'b1, 5'd4, 32'h0000_0077, 32'h0000_0077, 1'b0, 1'b1);
        send(32'h77, 1'b1, 5'd4, '0, TyW, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        wait_retire();

        tick();
        probe(PWbQ, 0);
        probe(PMtQ, 0);
        probe(PTimeouts, 0);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/segre_mem_stage.md
Name: segre_mem_stage

Overview:
Memory stage of the Segre pipeline, directly downstream of the execute stage. It registers the EX/MEM decoupling state and runs the load/store handshake with the data memory. Loads are aligned and sign- or zero-extended here. It produces the write-back payload and the MEM-stage bypass value that the execute stage consumes.

Parameters:
WORD_SIZE, 32, data word width
ADDR_SIZE, 32, address width
REG_SIZE, 5, register-file address width

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, synchronous, active-low
valid_ex_i  in  1  EX holds a valid instruction
alu_res_i  in  WORD_SIZE  ALU result / effective address
rf_we_i, rf_waddr_i, rf_st_data_i  in  1/REG_SIZE/WORD_SIZE  write enable, destination register, store data
memop_type_i  in  memop_data_type_e  byte/half/word
memop_rd_i, memop_wr_i, memop_sign_ext_i  in  1 each  load, store, sign-extend load
seq_new_pc_i  in  ADDR_SIZE  pc+4
is_jaljalr_i  in  1  instruction is JAL/JALR
block_mem_i  in  1  hold the EX/MEM register
inject_nops_i  in  1  load a bubble into the EX/MEM register
mem_req_o  out  1  data-memory request
mem_we_o  out  1  request is a store
mem_addr_o  out  ADDR_SIZE  word-aligned address
mem_be_o  out  4  byte enables
mem_wdata_o  out  WORD_SIZE  lane-shifted store data
mem_ack_i  in  1  one-cycle completion pulse
mem_rdata_i  in  WORD_SIZE  read word, valid while mem_ack_i=1
stall_mem_o  out  1  MEM busy; upstream stages must block
misaligned_o  out  1  misaligned access flagged
op_res_stage_mem_o  out  WORD_SIZE  bypass value for EX
rf_we_o, rf_waddr_o, rf_wdata_o  out  1/REG_SIZE/WORD_SIZE  write-back payload
valid_mem_o  out  1  WB may consume the payload this cycle

Behaviour:
- Reset (rsn_i=0 at a clock edge): valid_q, rf_we_q, rd_q and wr_q clear; FSM goes to IDLE. All outputs are 0 during and after reset.
- EX/MEM register update priority: rsn_i, then (block_mem_i | stall_mem_o) hold, then inject_nops_i (valid/we/rd/wr=0), then load inputs.
- Memop condition: memop = valid_q & (rd_q | wr_q).
- Misalignment: misaligned = memop & ((half & addr[0]) | (word & addr[1:0]!=0)). Combinational, visible in the same cycle.
- A misaligned access issues no request and forces rf_we_o=0. valid_mem_o still asserts so the instruction retires.
- FSM states:
  - IDLE: if memop and aligned, mem_req_o=1. mem_ack_i the same cycle means the access completes and the FSM stays in IDLE (stall_mem_o=0). If block_mem_i is also set, go to DONE. With no ack, go to WAIT (stall_mem_o=1).
  - WAIT: mem_req_o=1 and stall_mem_o=1. Request fields are stable. On mem_ack_i, capture mem_rdata_i into rdata_q. Then go to IDLE, or to DONE if block_mem_i=1. In the ack cycle stall_mem_o=0.
  - DONE: request complete, awaiting block_mem_i=0. mem_req_o=0 and the load data comes from rdata_q. Return to IDLE when block_mem_i=0.
  - No request is ever re-issued for the same instruction.
- Store lane and enable rules:
  - byte: be = 1<<addr[1:0], data replicated ×4.
  - half: be = 3<<addr[1:0], data replicated ×2.
  - word: be = 4'hF.
- mem_addr_o = {alu_res_q[ADDR_SIZE-1:2], 2'b00}.
- Load extract: select the byte/half at addr[1:0], then sign-extend if memop_sign_ext_q, otherwise zero-extend.
- The load data source is mem_rdata_i in the ack cycle, else rdata_q.
- rf_wdata_o priority: load data if rd_q; else seq_new_pc_q if is_jaljalr_q; else alu_res_q.
- op_res_stage_mem_o has the same selection as rf_wdata_o, except a load in progress returns alu_res_q. The controller must not bypass loads from MEM.
- valid_mem_o = valid_q & ~stall_mem_o & ~block_mem_i.
- rf_we_o = rf_we_q & valid_mem_o & ~misaligned.
- mem_ack_i outside WAIT or the IDLE issue cycle is ignored.
- Reset mid-WAIT abandons the access: FSM goes to IDLE and mem_req_o drops in the next cycle.

Test Plan:
- ALU op: alu_res=0x1234, rf_we=1, waddr=5 → after 1 clk: rf_wdata_o=0x1234, rf_we_o=1, valid_mem_o=1, mem_req_o=0.
- LB sign-extended, addr 0x103, ack after 3 cycles with rdata=0x80FF_0000 → stall_mem_o=1 for 3 cycles. In the ack cycle rf_wdata_o=0xFFFF_FF80 and mem_addr_o=0x100.
- SH addr 0x202, data 0xABCD, same-cycle ack → mem_be_o=4'b1100, mem_wdata_o=0xABCD_ABCD, mem_we_o=1, rf_we_o=0, no stall.
- LW addr 0x301 → misaligned_o=1, mem_req_o=0, rf_we_o=0, valid_mem_o=1.
- LHU addr 0x002, ack with rdata=0x9876_0000 while block_mem_i=1 for 2 cycles → FSM enters DONE, one request only. After the release rf_wdata_o=0x0000_9876.
- Assert rsn_i=0 during WAIT → next cycle mem_req_o=0 and all outputs 0. inject_nops_i then gives valid_mem_o=0.
